// File: rtl/fir_inverse_iir.sv
// fir_inverse_iir: recursive inverse of the 3-tap FIR stage.
//   y[n] = x[n] - b*y[n-1] - c*y[n-2]   (all arithmetic mod 2^WIDTH)
// A single WIDTH x WIDTH multiplier is shared across two cycles by a small
// FSM (IDLE -> MUL_B -> MUL_C -> HOLD). Valid/ready handshake on both sides.
module fir_inverse_iir #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,        // asynchronous, active-low
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] x_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL_B = 2'd1,
    MUL_C = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t state, state_next;

  // Sample, coefficients and recursion history.
  logic [WIDTH-1:0] x_lat, b_lat, c_lat;
  logic [WIDTH-1:0] y1, y2;
  logic [WIDTH-1:0] acc;

  // Shared multiplier operands and truncated product.
  logic [WIDTH-1:0] mul_a, mul_b;
  logic [WIDTH-1:0] prod;
  logic [WIDTH-1:0] r;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic and the input-side handshake.
  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned (which would infer a latch).
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = MUL_B;
      end
      MUL_B:   state_next = MUL_C;
      MUL_C:   state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand select for the one shared multiplier; idle inputs are held at zero.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      MUL_B: begin
        mul_a = b_lat;
        mul_b = y1;
      end
      MUL_C: begin
        mul_a = c_lat;
        mul_b = y2;
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase
  end

  // Assigning to a WIDTH-bit net keeps only the low bits of the product,
  // matching the FIR multiplier's truncation.
  assign prod = mul_a * mul_b;
  assign r    = acc - prod;

  // Datapath: latch on accept, two multiply-accumulate steps, then hold the
  // result until the downstream takes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_lat     <= '0;
      b_lat     <= '0;
      c_lat     <= '0;
      y1        <= '0;
      y2        <= '0;
      acc       <= '0;
      y         <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_lat <= x_in;
            b_lat <= b;
            c_lat <= c;
          end
        end
        MUL_B: acc <= x_lat - prod;
        MUL_C: begin
          y         <= r;
          y1        <= r;
          y2        <= y1;
          out_valid <= 1'b1;
        end
        HOLD: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fir_inverse_iir.md
Name: fir_inverse_iir

Overview:
- Recursive (IIR) inverse of the 3-tap FIR stage: y[n] = x[n] - b*y[n-1] - c*y[n-2], all arithmetic mod 256.
- Cascading FIR(a=1, b, c) -> fir_inverse_iir(b, c) returns the original FIR input sample-for-sample. The block serves as the receive-side equaliser and as the FIR self-check.
- Time-multiplexed: one shared 8x8 multiplier driven by a small FSM.
- Valid/ready handshake on both sides.

Parameters:
- WIDTH, 8, sample and coefficient width. All arithmetic is truncated to WIDTH bits (two's-complement wrap).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- b  input  WIDTH  feedback coefficient for y[n-1]; sampled on input accept
- c  input  WIDTH  feedback coefficient for y[n-2]; sampled on input accept
- x_in  input  WIDTH  input sample
- in_valid  input  1  x_in valid
- in_ready  output  1  block can accept a sample
- y  output  WIDTH  filtered output sample
- out_valid  output  1  y valid
- out_ready  input  1  downstream accepts y

Behaviour:
- One clock domain. Reset is asynchronous and active-low on rst, using the clk/rst port names.
- Reset (rst=0, any time, including mid-operation):
  - state=IDLE; y1=0, y2=0, acc=0, y=0, out_valid=0; latched b/c/x = 0.
  - in_ready=1 from the first cycle after release.
  - Any sample in flight is discarded.
- Multiply: low WIDTH bits of the unsigned WIDTH x WIDTH product, the same truncation as the FIR multiplier.
- Add/subtract: mod 2^WIDTH, with no saturation.
- FSM states: IDLE, MUL_B, MUL_C, HOLD.
  - IDLE:
    - in_ready=1.
    - On in_valid=1 at a rising edge: latch x_in, b, c; go to MUL_B.
    - Otherwise stay in IDLE.
  - MUL_B:
    - in_ready=0.
    - Multiplier operands are (b_lat, y1); acc <= x_lat - b_lat*y1.
    - Go to MUL_C.
  - MUL_C:
    - in_ready=0.
    - Operands are (c_lat, y2); r = acc - c_lat*y2.
    - Update y <= r, y1 <= r, y2 <= y1; out_valid <= 1.
    - Go to HOLD.
  - HOLD:
    - in_ready=0; y and out_valid held stable.
    - On out_ready=1 at an edge: out_valid <= 0; go to IDLE.
    - Otherwise stay, with unlimited backpressure.
- Latency and throughput:
  - Sample accepted at edge k; out_valid=1 and y valid after edge k+2.
  - With out_ready held at 1: out_valid drops after edge k+3, and the next accept is at edge k+4.
  - Maximum throughput is 1 sample per 4 cycles.
- Coefficient changes while busy have no effect on the sample in flight. The new values apply from the next accept.
- in_valid asserted outside IDLE is ignored; the upstream must hold x_in/in_valid until in_ready.
- y keeps its last value after the handshake completes. Only out_valid qualifies it.
- History y1/y2 persists across idle gaps of any length. Only reset clears it.
- The multiplier is shared: exactly one multiply per cycle, in MUL_B and MUL_C only.

Test Plan:
- Reset mid-operation: accept x=9, b=2, c=1, assert rst=0 in MUL_C. Required: out_valid=0 and y=0 immediately; after release, x=7 gives y=7 (history cleared).
- Impulse response: b=3, c=5, x = 1,0,0,0 with out_ready=1. Required: y = 1, 253, 4, 3. Each out_valid appears 2 cycles after accept; accepts are 4 cycles apart.
- Passthrough: b=0, c=0, x = 0x00, 0x7F, 0x80, 0xFF. Required: y equals x for every sample.
- Backpressure: b=1, c=0, x = 10, 20, with out_ready=0 for 6 cycles after the first result. Required:
  - y=10 held with out_valid=1 and in_ready=0 throughout.
  - After out_ready=1: second result y = 20-10 = 10.
- Wrap-around: b=0xFF, c=0xFF, x = 1,1. Required: y0=1; y1 = 1-255 = 2 (mod 256).
- Round trip: 200 random x through FIR(a=1, b, c) then this block with the same b and c, with random in_valid/out_ready gaps. Required: output stream equals the FIR input stream exactly; coefficient changes mid-sample take effect on the next sample only.
